// File: rtl/ni_inject_pkg.sv
// Shared definitions for the network-interface injection stage: field widths, head-flit layout,
// flit type codes, FSM states and a head-payload builder.
package ni_inject_pkg;

    // Field widths
    localparam int unsigned X_W    = 3;
    localparam int unsigned Y_W    = 3;
    localparam int unsigned ID_W   = 6;
    localparam int unsigned LEN_FW = 8;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned PAY_W  = 42;
    localparam int unsigned DATA_W = PAY_W + 2;

    // Head-flit field offsets within the payload
    localparam int unsigned DST_X_LSB  = 0;
    localparam int unsigned DST_Y_LSB  = 3;
    localparam int unsigned SRC_X_LSB  = 6;
    localparam int unsigned SRC_Y_LSB  = 9;
    localparam int unsigned SRC_ID_LSB = 12;
    localparam int unsigned LEN_LSB    = 18;
    localparam int unsigned TS_LSB     = 26;

    // Flit type lives in the top two bits of a flit
    typedef enum logic [1:0] {
        FlitBody     = 2'b00,
        FlitTail     = 2'b01,
        FlitHead     = 2'b10,
        FlitHeadTail = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StVcSel = 2'd1,
        StHead  = 2'd2,
        StBody  = 2'd3
    } ni_state_e;

    function automatic logic [PAY_W-1:0] head_payload(
        input logic [X_W-1:0]    dst_x,
        input logic [Y_W-1:0]    dst_y,
        input logic [X_W-1:0]    src_x,
        input logic [Y_W-1:0]    src_y,
        input logic [ID_W-1:0]   src_id,
        input logic [LEN_FW-1:0] len,
        input logic [TS_W-1:0]   ts
    );
        logic [PAY_W-1:0] p;
        p = '0;
        p[DST_X_LSB  +: X_W]    = dst_x;
        p[DST_Y_LSB  +: Y_W]    = dst_y;
        p[SRC_X_LSB  +: X_W]    = src_x;
        p[SRC_Y_LSB  +: Y_W]    = src_y;
        p[SRC_ID_LSB +: ID_W]   = src_id;
        p[LEN_LSB    +: LEN_FW] = len;
        p[TS_LSB     +: TS_W]   = ts;
        return p;
    endfunction

endpackage

// File: rtl/ni_vc_arb.sv
// Round-robin virtual-channel arbiter: first eligible VC at or after the pointer wins.
module ni_vc_arb
    import ni_inject_pkg::*;
#(
    parameter int unsigned NVCH = 2,
    localparam int unsigned VW  = (NVCH > 1) ? $clog2(NVCH) : 1
) (
    input  logic [NVCH-1:0] eligible,
    input  logic [VW-1:0]   ptr,
    output logic            grant,
    output logic [VW-1:0]   grant_id
);

    // Scan VCs starting at the pointer, wrapping at NVCH
    always_comb begin
        logic [VW-1:0] idx;
        grant    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NVCH; i++) begin
            idx = VW'((32'(ptr) + i) % NVCH);
            if (!grant && eligible[idx]) begin
                grant    = 1'b1;
                grant_id = idx;
            end
        end
    end

endmodule

// File: rtl/ni_inject.sv
// Network-interface injection stage: turns core packet requests and payload words into
// head/body/tail flits on a round-robin allocated VC of the router local port.
// Optional macro NI_TIMESTAMP_EN adds a free-running cycle counter stamped into head flits.
module ni_inject
    import ni_inject_pkg::*;
#(
    parameter int unsigned ROUTERID = 0,
    parameter int unsigned MY_XPOS  = 0,
    parameter int unsigned MY_YPOS  = 0,
    parameter int unsigned NVCH     = 2,
    parameter int unsigned LENW     = 4,
    localparam int unsigned VW      = (NVCH > 1) ? $clog2(NVCH) : 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [X_W-1:0]    req_dst_x,
    input  logic [Y_W-1:0]    req_dst_y,
    input  logic [LENW-1:0]   req_len,
    input  logic [PAY_W-1:0]  pay_data,
    input  logic              pay_valid,
    output logic              pay_ready,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VW-1:0]     ovch,
    input  logic [NVCH-1:0]   iack,
    input  logic [NVCH-1:0]   irdy,
    input  logic [NVCH-1:0]   ilck
);

    ni_state_e         state_q, state_d;
    logic [X_W-1:0]    dst_x_q, dst_x_d;
    logic [Y_W-1:0]    dst_y_q, dst_y_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   rem_q, rem_d;
    logic [VW-1:0]     vc_q, vc_d;
    logic [VW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              ovalid_q, ovalid_d;
    logic              req_ready_q;
    logic              req_fire;
    logic              ack;
    logic              arb_grant;
    logic [VW-1:0]     arb_id;
    logic [TS_W-1:0]   ts_val;

    assign req_ready = req_ready_q;
    assign odata     = odata_q;
    assign ovalid    = ovalid_q;
    assign ovch      = vc_q;
    assign req_fire  = (state_q == StIdle) && req_valid && req_ready_q;
    // Acks only count against a flit actually on the wire, on our own VC
    assign ack       = ovalid_q && iack[vc_q];

    ni_vc_arb #(
        .NVCH (NVCH)
    ) u_vc_arb (
        .eligible (irdy & ~ilck),
        .ptr      (ptr_q),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

`ifdef NI_TIMESTAMP_EN
    logic [TS_W-1:0] cnt_q, ts_q;

    // Free-running cycle counter, sampled when a request is accepted
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
            ts_q  <= '0;
        end else begin
            cnt_q <= cnt_q + TS_W'(1);
            if (req_fire) ts_q <= cnt_q;
        end
    end

    assign ts_val = ts_q;
`else
    assign ts_val = '0;
`endif

    // Next-state, flit construction and payload handshake
    always_comb begin
        state_d   = state_q;
        dst_x_d   = dst_x_q;
        dst_y_d   = dst_y_q;
        len_d     = len_q;
        rem_d     = rem_q;
        vc_d      = vc_q;
        ptr_d     = ptr_q;
        odata_d   = odata_q;
        ovalid_d  = ovalid_q;
        pay_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    dst_x_d = req_dst_x;
                    dst_y_d = req_dst_y;
                    len_d   = req_len;
                    state_d = StVcSel;
                end
            end
            StVcSel: begin
                if (arb_grant) begin
                    vc_d     = arb_id;
                    ptr_d    = (arb_id == VW'(NVCH - 1)) ? '0 : arb_id + VW'(1);
                    odata_d  = {(len_q == '0) ? FlitHeadTail : FlitHead,
                                head_payload(dst_x_q, dst_y_q, X_W'(MY_XPOS), Y_W'(MY_YPOS),
                                             ID_W'(ROUTERID), LEN_FW'(len_q), ts_val)};
                    ovalid_d = 1'b1;
                    state_d  = StHead;
                end
            end
            StHead: begin
                if (ack) begin
                    ovalid_d = 1'b0;
                    odata_d  = '0;
                    if (len_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        rem_d   = len_q;
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (ack) begin
                    ovalid_d = 1'b0;
                    odata_d  = '0;
                    rem_d    = rem_q - LENW'(1);
                    if (rem_q == LENW'(1)) state_d = StIdle;
                end else if (!ovalid_q && pay_valid && irdy[vc_q]) begin
                    // Only one flit in flight; a new word is taken once the last one is acked
                    pay_ready = 1'b1;
                    odata_d   = {(rem_q == LENW'(1)) ? FlitTail : FlitBody, pay_data};
                    ovalid_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= StIdle;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            vc_q        <= '0;
            ptr_q       <= '0;
            odata_q     <= '0;
            ovalid_q    <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dst_x_q     <= dst_x_d;
            dst_y_q     <= dst_y_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            vc_q        <= vc_d;
            ptr_q       <= ptr_d;
            odata_q     <= odata_d;
            ovalid_q    <= ovalid_d;
            req_ready_q <= (state_d == StIdle);
        end
    end

endmodule

// File: tb/tb_ni_inject.sv
// Randomized self-checking bench for ni_inject with a packet-level reference model.
module tb_ni_inject;

    localparam int unsigned RID  = 5;
    localparam int unsigned MX   = 2;
    localparam int unsigned MY   = 3;

    logic        clk = 1'b0;
    logic        rst_;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_dst_x;
    logic [2:0]  req_dst_y;
    logic [3:0]  req_len;
    logic [41:0] pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [43:0] odata;
    logic        ovalid;
    logic [0:0]  ovch;
    logic [1:0]  iack;
    logic [1:0]  irdy;
    logic [1:0]  ilck;

    int vectors     = 0;
    int miscompares = 0;
    int ptr_m       = 0;
    logic [15:0] tcount;

    ni_inject #(
        .ROUTERID (RID),
        .MY_XPOS  (MX),
        .MY_YPOS  (MY),
        .NVCH     (2),
        .LENW     (4)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dst_x (req_dst_x),
        .req_dst_y (req_dst_y),
        .req_len   (req_len),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .odata     (odata),
        .ovalid    (ovalid),
        .ovch      (ovch),
        .iack      (iack),
        .irdy      (irdy),
        .ilck      (ilck)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release, mirrors the timestamp counter's definition
    always @(posedge clk or negedge rst_) begin
        if (!rst_) tcount <= 16'd0;
        else       tcount <= tcount + 16'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_pkt(input int dx, input int dy, input int len, input logic [1:0] rdy,
                           input logic [1:0] lck, input int hold, input int ack_dly,
                           input int gap, input int abort_at, input bit rnd);
        logic [43:0] expq[$];
        logic [41:0] words[$];
        logic [15:0] ts;
        logic [1:0]  elig;
        logic [63:0] hd;
        int vc, pulses, acked, total, since, gap_left, k, budget;
        bit granted, ackit, held, exp_pr, body;
        vc = 0; pulses = 0; acked = 0; total = len + 1; since = 0; gap_left = 0;
        granted = 0; held = 0;
        for (int i = 0; i < len; i++) words.push_back(42'({$urandom, $urandom}));

        @(negedge clk);
        req_valid = 1'b1;
        req_dst_x = 3'(dx);
        req_dst_y = 3'(dy);
        req_len   = 4'(len);
        irdy      = (hold > 0) ? 2'b00 : rdy;
        ilck      = lck;
        iack      = 2'b00;
        pay_valid = 1'b0;
        budget = 20;
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("req_ready", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
`ifdef NI_TIMESTAMP_EN
        ts = tcount;
`else
        ts = 16'd0;
`endif
        @(negedge clk);
        req_valid = 1'b0;

        // VC selection: model grants the first eligible VC from its own pointer
        k = 0;
        while (!granted && k < 40) begin
            check("vcsel_quiet", ovalid, 0);
            check("vcsel_req_ready", req_ready, 0);
            if (k >= hold) irdy = rdy;
            elig = irdy & ~ilck;
            for (int i = 0; i < 2; i++) begin
                int v;
                v = (ptr_m + i) % 2;
                if (!granted && elig[v]) begin
                    granted = 1;
                    vc      = v;
                end
            end
            if (granted) begin
                ptr_m = (vc + 1) % 2;
                hd = (64'(ts) << 26) | (64'(len) << 18) | (64'(RID) << 12) | (64'(MY) << 9)
                   | (64'(MX) << 6) | (64'(dy) << 3) | 64'(dx);
                expq.push_back({(len == 0) ? 2'b11 : 2'b10, hd[41:0]});
            end
            @(negedge clk);
            k++;
        end
        check("vc_grant", granted, 1);
        if (!granted) return;
        check("head_latency", ovalid, 1);

        budget = 600;
        while (acked < total && budget > 0) begin
            if (abort_at > 0 && acked == abort_at && ovalid) begin
                #2 rst_ = 1'b0;
                #1;
                check("rst_odata", odata, 0);
                check("rst_ovalid", ovalid, 0);
                check("rst_ovch", ovch, 0);
                check("rst_req_ready", req_ready, 0);
                check("rst_pay_ready", pay_ready, 0);
                ptr_m = 0;
                iack = 2'b00;
                pay_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_ = 1'b1;
                return;
            end
            if (held) check("hold_valid", ovalid, 1);
            body  = (acked >= 1);
            ackit = 0;
            if (ovalid) begin
                if (expq.size() > 0) begin
                    check("flit_vch", ovch, vc);
                    check("flit_data", odata, expq[0]);
                end else begin
                    check("spurious_flit", ovalid, 0);
                end
                since++;
                ackit = (since > ack_dly) && (!rnd || $urandom_range(0, 2) != 0);
                iack = 2'b00;
                if (ackit) iack[vc] = 1'b1;
                else if (rnd) iack[1-vc] = 1'($urandom_range(0, 1));
            end else begin
                since = 0;
                iack  = rnd ? 2'($urandom) : 2'b00;
            end
            held = ovalid && !ackit;
            if (rnd) begin
                irdy     = 2'($urandom);
                irdy[vc] = ($urandom_range(0, 3) != 0);
                ilck     = 2'($urandom);
            end
            if (pulses < len) begin
                pay_data = words[pulses];
                if (gap_left > 0) begin
                    pay_valid = 1'b0;
                    gap_left--;
                end else begin
                    pay_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end else begin
                pay_valid = rnd ? 1'($urandom) : 1'b0;
                pay_data  = 42'({$urandom, $urandom});
            end
            #1;
            exp_pr = body && !ovalid && pay_valid && irdy[vc];
            check("pay_ready", pay_ready, exp_pr);
            if (pay_ready && pulses < len) begin
                expq.push_back({(pulses == len - 1) ? 2'b01 : 2'b00, words[pulses]});
                pulses++;
                if (pulses == 1) gap_left = gap;
            end
            if (ackit && expq.size() > 0) begin
                void'(expq.pop_front());
                acked++;
            end
            @(negedge clk);
            budget--;
        end
        check("flits_acked", acked, total);
        check("pay_pulses", pulses, len);
        iack      = 2'b00;
        pay_valid = 1'b0;
        check("idle_req_ready", req_ready, 1);
        check("idle_ovalid", ovalid, 0);
    endtask

    initial begin
        logic [1:0] r, l;
        rst_      = 1'b0;
        req_valid = 1'b0;
        req_dst_x = '0;
        req_dst_y = '0;
        req_len   = '0;
        pay_data  = '0;
        pay_valid = 1'b0;
        iack      = 2'b00;
        irdy      = 2'b00;
        ilck      = 2'b00;
        #22;
        check("reset_req_ready", req_ready, 0);
        check("reset_pay_ready", pay_ready, 0);
        check("reset_odata", odata, 0);
        check("reset_ovalid", ovalid, 0);
        check("reset_ovch", ovch, 0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", req_ready, 1);

        // Single head-tail flit
        run_pkt(2, 1, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        // Head + two bodies + tail
        run_pkt(3, 4, 3, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        // Locked VC0 forces VC1, then round-robin across both
        run_pkt(1, 1, 1, 2'b11, 2'b01, 0, 0, 0, 0, 0);
        run_pkt(5, 2, 2, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        run_pkt(6, 7, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        // No buffer space for a while, then only VC1
        run_pkt(0, 3, 1, 2'b10, 2'b00, 4, 0, 0, 0, 0);
        // Payload gap and slow acks
        run_pkt(4, 4, 4, 2'b11, 2'b00, 0, 2, 3, 0, 0);
        // Reset with a body flit pending, then a fresh packet
        run_pkt(7, 0, 3, 2'b11, 2'b00, 0, 0, 0, 2, 0);
        run_pkt(1, 2, 1, 2'b11, 2'b00, 0, 0, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            do begin
                r = 2'($urandom);
                l = 2'($urandom);
            end while ((r & ~l) == 2'b00);
            run_pkt($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15), r, l,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
